bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq_pkg.sv | 12 +
 rtl/bin2bcd_seq_dabble_digit.sv | 12 +
 rtl/bin2bcd_seq.sv | 117 +++++++++++
 tb/tb_bin2bcd_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH  = 14;
  localparam int DEF_DIGITS = 4;
  localparam int BCD_W      = 4;
endpackage

// File: rtl/bin2bcd_seq_dabble_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more, pure combinational.
module dabble_digit
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] d_i,
  output logic [BCD_W-1:0] d_o
);
  always_comb begin
    d_o = d_i;
    if (d_i >= BCD_W'(5)) d_o = d_i + BCD_W'(3);
  end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with latched display outputs.
// Optional leading-zero blanking of the anode mask when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      start,
  input  logic [WIDTH-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]         aen,
  output logic                      ovf
);
  localparam int AW = BCD_W * (DIGITS + 1);
  localparam int CW = $clog2(WIDTH + 1);

`ifdef BIN2BCD_BLANK_EN
  localparam logic [DIGITS-1:0] AEN_RST = DIGITS'(1);
`else
  localparam logic [DIGITS-1:0] AEN_RST = '1;
`endif

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q;
  logic [WIDTH-1:0]          opnd_q;
  logic [AW-1:0]             acc_q, acc_fix;
  logic                      cout_q;
  logic [BCD_W*DIGITS-1:0]   bcd_q;
  logic [DIGITS-1:0]         aen_q, aen_d;
  logic                      ovf_q;
  logic                      accept, shift_en, finish;

  assign accept   = start && (state_q != ST_SHIFT);
  assign shift_en = (state_q == ST_SHIFT) && (cnt_q != '0);
  assign finish   = (state_q == ST_SHIFT) && (cnt_q == '0);

  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_dd
    dabble_digit u_dd (
      .d_i (acc_q[BCD_W*g +: BCD_W]),
      .d_o (acc_fix[BCD_W*g +: BCD_W])
    );
  end

  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
  end

  // Mask derived from the result about to be latched (low DIGITS of the accumulator).
  always_comb begin
`ifdef BIN2BCD_BLANK_EN
    logic nz;
    nz    = 1'b0;
    aen_d = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nz       = nz | (|acc_q[BCD_W*i +: BCD_W]);
      aen_d[i] = nz;
    end
    aen_d[0] = 1'b1;
`else
    aen_d = '1;
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      opnd_q <= '0;
      acc_q  <= '0;
      cout_q <= 1'b0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      aen_q  <= AEN_RST;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        opnd_q <= bin;
        acc_q  <= '0;
        cout_q <= 1'b0;
        cnt_q  <= CW'(WIDTH);
      end else if (shift_en) begin
        cout_q <= cout_q | acc_fix[AW-1];
        acc_q  <= {acc_fix[AW-2:0], opnd_q[WIDTH-1]};
        opnd_q <= {opnd_q[WIDTH-2:0], 1'b0};
        cnt_q  <= cnt_q - CW'(1);
      end
      if (finish) begin
        bcd_q <= acc_q[BCD_W*DIGITS-1:0];
        ovf_q <= (|acc_q[AW-1 -: BCD_W]) | cout_q;
        aen_q <= aen_d;
      end
    end
  end

  assign bcd = bcd_q;
  assign aen = aen_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq with hand-computed BCD vectors.
module tb_bin2bcd_seq;
  logic        clk = 1'b0;
  logic        clr, start;
  logic [13:0] bin;
  logic        busy, done, ovf;
  logic [15:0] bcd;
  logic [3:0]  aen;

  int n_vec = 0;
  int n_err = 0;

  bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .aen   (aen),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from the accepting edge to the edge after which done is seen (capped at 40).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
  endtask

  task automatic count_dones(input int cycles, output int nd);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) nd++;
    end
  endtask

  function automatic logic [3:0] exp_aen(input logic [3:0] blanked);
`ifdef BIN2BCD_BLANK_EN
    return blanked;
`else
    return (blanked == 4'b0000) ? 4'b1111 : 4'b1111;
`endif
  endfunction

  task automatic convert(input string tag, input logic [13:0] v, input logic [15:0] e_bcd,
                         input logic e_ovf, input logic [3:0] e_aen_blank);
    int n;
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    wait_done(n);
    chk({tag, "_lat"}, n, 15);
    chk({tag, "_bcd"}, bcd, e_bcd);
    chk({tag, "_ovf"}, ovf, e_ovf);
    chk({tag, "_aen"}, aen, exp_aen(e_aen_blank));
    tick();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n, nd;
    clr   = 1'b1;
    start = 1'b0;
    bin   = '0;
    tick();
    start = 1'b1;
    bin   = 14'd77;
    tick();
    clr   = 1'b0;
    start = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd",  bcd,  0);
    chk("rst_ovf",  ovf,  0);

    convert("zero",  14'd0,     16'h0000, 1'b0, 4'b0001);
    convert("v1234", 14'd1234,  16'h1234, 1'b0, 4'b1111);
    convert("v42",   14'd42,    16'h0042, 1'b0, 4'b0011);
    convert("v9999", 14'd9999,  16'h9999, 1'b0, 4'b1111);
    convert("v10k",  14'd10000, 16'h0000, 1'b1, 4'b0001);
    convert("vmax",  14'd16383, 16'h6383, 1'b1, 4'b1111);

    // Start while busy is ignored.
    start = 1'b1;
    bin   = 14'd42;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    bin   = 14'd7;
    tick();
    start = 1'b0;
    bin   = '0;
    wait_done(n);
    chk("busy_ign_lat", n, 10);
    chk("busy_ign_bcd", bcd, 16'h0042);
    count_dones(20, nd);
    chk("busy_ign_extra_done", nd, 0);

    // Abort mid-conversion.
    start = 1'b1;
    bin   = 14'd500;
    tick();
    start = 1'b0;
    repeat (6) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bcd",  bcd,  0);
    count_dones(20, nd);
    chk("abort_no_done", nd, 0);
    convert("v321", 14'd321, 16'h0321, 1'b0, 4'b0111);

    // Back-to-back: start accepted in the done cycle.
    start = 1'b1;
    bin   = 14'd99;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("b2b_first_lat", n, 15);
    chk("b2b_first_bcd", bcd, 16'h0099);
    start = 1'b1;
    bin   = 14'd12;
    tick();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    wait_done(n);
    chk("b2b_lat", n, 15);
    chk("b2b_bcd", bcd, 16'h0012);
    chk("b2b_aen", aen, exp_aen(4'b0011));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
